// File: rtl/dpr_w_i.sv
// rtl/dpr_w_i.sv - dual-port W_i weight RAM with a run-time active region of m*gamma words
module dpr_w_i #(
    parameter int FEATURE_BITS = 4,
    parameter int ELEMENT_BITS = 8,
    parameter int RAM_DEPTH    = 2**(2*FEATURE_BITS)
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic [FEATURE_BITS-1:0]   m,
    input  logic [FEATURE_BITS-1:0]   gamma,
    input  logic [2*FEATURE_BITS-1:0] address_in,
    input  logic [ELEMENT_BITS-1:0]   data_in,
    input  logic                      cs_in,
    input  logic                      we_in,
    input  logic [2*FEATURE_BITS-1:0] address_out,
    input  logic                      oe_out,
    input  logic                      cs_out,
    output logic [ELEMENT_BITS-1:0]   data_out
);

    localparam int AW = 2*FEATURE_BITS;

    logic [ELEMENT_BITS-1:0] mem [RAM_DEPTH];
    logic [AW-1:0]           limit;
    logic                    wr_en;
    logic                    rd_en;
    logic                    rd_hit;

    assign limit  = AW'(m) * AW'(gamma);
    assign wr_en  = cs_in && we_in && (address_in < limit);
    assign rd_en  = cs_out && oe_out;
    assign rd_hit = address_out < limit;

    // Words must clear asynchronously on reset, so storage is built from resettable flops.
    // Nonblocking updates give read-before-write on a same-address collision.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else begin
            if (wr_en) begin
                mem[address_in] <= data_in;
            end
            if (rd_en) begin
                data_out <= rd_hit ? mem[address_out] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dpr_w_i.sv
// tb/tb_dpr_w_i.sv - randomized, model-checked bench for dpr_w_i
module tb_dpr_w_i;

    logic       sys_clk = 1'b0;
    logic       reset_n;
    logic [3:0] m;
    logic [3:0] gamma;
    logic [7:0] address_in;
    logic [7:0] data_in;
    logic       cs_in;
    logic       we_in;
    logic [7:0] address_out;
    logic       oe_out;
    logic       cs_out;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fails  = 0;
    logic chk_en = 1'b0;

    logic [7:0] model_mem [256];
    logic [7:0] exp_dout;
    logic [7:0] wr [256];
    logic [7:0] hold;

    dpr_w_i #(.FEATURE_BITS(4), .ELEMENT_BITS(8)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .m(m), .gamma(gamma),
        .address_in(address_in), .data_in(data_in), .cs_in(cs_in), .we_in(we_in),
        .address_out(address_out), .oe_out(oe_out), .cs_out(cs_out), .data_out(data_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: a plain array; the read is resolved before the write on the same edge.
    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
            exp_dout = 8'h00;
        end else begin
            int lim;
            lim = int'(m) * int'(gamma);
            if (cs_out && oe_out)
                exp_dout = (int'(address_out) < lim) ? model_mem[address_out] : 8'h00;
            if (cs_in && we_in && int'(address_in) < lim)
                model_mem[address_in] = data_in;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) check("model", data_out, exp_dout);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        cs_in = 0; we_in = 0; cs_out = 0; oe_out = 0;
    endtask

    task automatic read_at(input logic [7:0] a);
        cs_in = 0; we_in = 0;
        address_out = a; cs_out = 1; oe_out = 1;
        tick();
    endtask

    task automatic write_at(input logic [7:0] a, input logic [7:0] d);
        cs_out = 0; oe_out = 0;
        address_in = a; data_in = d; cs_in = 1; we_in = 1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        exp_dout = 8'h00;
        reset_n = 0;
        m = 4'($urandom); gamma = 4'($urandom);
        address_in = 8'($urandom); data_in = 8'($urandom);
        address_out = 8'($urandom);
        cs_in = 1; we_in = 1; cs_out = 1; oe_out = 1;
        #2;
        check("reset_async", data_out, 8'h00);
        repeat (3) tick();
        check("reset_hold", data_out, 8'h00);
        idle();
        m = 4'd9; gamma = 4'd3;
        tick();
        reset_n = 1;
        chk_en = 1;
        tick();

        for (int a = 0; a < 27; a++) begin
            read_at(8'(a));
            check("post_reset_rd", data_out, 8'h00);
        end

        for (int a = 0; a < 27; a++) begin
            wr[a] = 8'($urandom);
            write_at(8'(a), wr[a]);
        end
        for (int a = 0; a < 27; a++) begin
            read_at(8'(a));
            check("fill_rd", data_out, wr[a]);
        end

        write_at(8'd27, 8'hAA);
        read_at(8'd27);
        check("oor_rd_g3", data_out, 8'h00);
        gamma = 4'd4;
        read_at(8'd27);
        check("oor_rd_g4", data_out, 8'h00);
        write_at(8'd27, 8'h55);
        read_at(8'd27);
        check("oor_rd_55", data_out, 8'h55);
        gamma = 4'd3;
        read_at(8'd27);
        check("shrunk_rd", data_out, 8'h00);
        gamma = 4'd4;
        read_at(8'd27);
        check("regrow_rd", data_out, 8'h55);
        gamma = 4'd3;

        cs_out = 0; oe_out = 0;
        address_in = 8'd5; data_in = 8'hFF; cs_in = 1; we_in = 0;
        tick();
        read_at(8'd5);
        check("we_gate", data_out, wr[5]);
        hold = data_out;
        for (int k = 0; k < 3; k++) begin
            address_out = 8'(k * 7 + 1); cs_out = 0; oe_out = 1;
            tick();
            check("cs_hold", data_out, hold);
            address_out = 8'(k * 5 + 2); cs_out = 1; oe_out = 0;
            tick();
            check("oe_hold", data_out, hold);
        end

        write_at(8'd3, 8'h11);
        address_in = 8'd3; data_in = 8'h22; cs_in = 1; we_in = 1;
        address_out = 8'd3; cs_out = 1; oe_out = 1;
        tick();
        check("collide_old", data_out, 8'h11);
        read_at(8'd3);
        check("collide_new", data_out, 8'h22);

        for (int c = 0; c < 600; c++) begin
            int lim;
            if (c % 25 == 0) begin
                m = {3'($urandom_range(0, 7)), 1'b1};
                gamma = 4'($urandom_range(0, 15));
            end
            lim = int'(m) * int'(gamma);
            address_in  = ($urandom_range(0, 3) != 0 && lim > 0) ? 8'($urandom_range(0, lim - 1)) : 8'($urandom);
            address_out = ($urandom_range(0, 3) != 0 && lim > 0) ? 8'($urandom_range(0, lim - 1)) : 8'($urandom);
            if ($urandom_range(0, 7) == 0) address_out = address_in;
            data_in = 8'($urandom);
            cs_in  = ($urandom_range(0, 3) != 0);
            we_in  = ($urandom_range(0, 3) != 0);
            cs_out = ($urandom_range(0, 3) != 0);
            oe_out = ($urandom_range(0, 3) != 0);
            tick();
        end

        m = 4'd9; gamma = 4'd3;
        for (int a = 0; a < 27; a++) begin
            wr[a] = 8'($urandom_range(1, 255));
            write_at(8'(a), wr[a]);
        end
        for (int a = 0; a < 8; a++) begin
            read_at(8'(a));
            check("pre_rst_rd", data_out, wr[a]);
        end
        #2;
        reset_n = 0;
        #1;
        check("midsweep_rst", data_out, 8'h00);
        tick();
        tick();
        reset_n = 1;
        for (int a = 0; a < 27; a++) begin
            read_at(8'(a));
            check("post_rst_rd", data_out, 8'h00);
        end
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
